// File: rtl/reservation_entry_gen.sv
// Single reservation-station entry: captures a dispatched instruction, snoops the
// CDB channels to wake pending operands, optionally waits for its in-order slot,
// and tracks a saturating age for oldest-first selection. Held until issue grant.
module reservation_entry_gen #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned SRC_N   = 2,
    parameter int unsigned CDB_CH  = 3,
    parameter int unsigned PAY_W   = 52,
    parameter int unsigned PTR_W   = 4,
    parameter int unsigned INORDER = 1,
    parameter int unsigned AGE_W   = 4
) (
    input  logic                     iCLOCK,
    input  logic                     inRESET,
    input  logic                     iREMOVE_VALID,
    input  logic                     iREGIST_VALID,
    input  logic [PAY_W-1:0]         iREGIST_PAYLOAD,
    input  logic [SRC_N-1:0]         iREGIST_SRC_VALID,
    input  logic [SRC_N-1:0]         iREGIST_SRC_SYSREG,
    input  logic [SRC_N*DATA_W-1:0]  iREGIST_SRC_DATA,
    input  logic [PTR_W-1:0]         iREGIST_EX_POINTER,
    input  logic [CDB_CH-1:0]        iCDB_VALID,
    input  logic [CDB_CH-1:0]        iCDB_WRITEBACK,
    input  logic [CDB_CH*TAG_W-1:0]  iCDB_REGNAME,
    input  logic [CDB_CH*DATA_W-1:0] iCDB_DATA,
    input  logic [PTR_W-1:0]         iEX_EXECUTION_POINTER,
    input  logic                     iISSUE_GRANT,
    output logic                     oINFO_ENTRY_VALID,
    output logic                     oINFO_MATCHING,
    output logic [PAY_W-1:0]         oINFO_PAYLOAD,
    output logic [SRC_N-1:0]         oINFO_SRC_VALID,
    output logic [SRC_N-1:0]         oINFO_SRC_SYSREG,
    output logic [SRC_N*DATA_W-1:0]  oINFO_SRC_DATA,
    output logic [AGE_W-1:0]         oINFO_AGE
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [PAY_W-1:0]                payload_q, payload_d;
    logic [SRC_N-1:0]                src_valid_q, src_valid_d;
    logic [SRC_N-1:0]                src_sysreg_q, src_sysreg_d;
    logic [SRC_N-1:0][DATA_W-1:0]    src_data_q, src_data_d;
    logic [PTR_W-1:0]                ptr_q, ptr_d;
    logic                            ptr_match_q, ptr_match_d;
    logic [AGE_W-1:0]                age_q, age_d;
    logic                            matching_q, matching_d;

    logic [SRC_N-1:0][DATA_W-1:0]    regist_data_c;
    logic [CDB_CH-1:0][TAG_W-1:0]    cdb_name_c;
    logic [CDB_CH-1:0][DATA_W-1:0]   cdb_data_c;
    logic [SRC_N-1:0][TAG_W-1:0]     snoop_tag_c;
    logic [SRC_N-1:0]                hit_c;
    logic [SRC_N-1:0][DATA_W-1:0]    hit_data_c;
    logic                            clear_c;

    assign regist_data_c = iREGIST_SRC_DATA;
    assign cdb_name_c    = iCDB_REGNAME;
    assign cdb_data_c    = iCDB_DATA;

    // Tag each source compares against: incoming tag while idle, stored tag while waiting
    always_comb begin
        snoop_tag_c = '0;
        for (int s = 0; s < int'(SRC_N); s++) begin
            if (state_q == ST_IDLE) begin
                snoop_tag_c[s] = regist_data_c[s][TAG_W-1:0];
            end else begin
                snoop_tag_c[s] = src_data_q[s][TAG_W-1:0];
            end
        end
    end

    // CDB match per source; scanning from the top down lets the lowest channel win
    always_comb begin
        hit_c      = '0;
        hit_data_c = '0;
        for (int s = 0; s < int'(SRC_N); s++) begin
            for (int c = int'(CDB_CH) - 1; c >= 0; c--) begin
                if (iCDB_VALID[c] && iCDB_WRITEBACK[c] && (cdb_name_c[c] == snoop_tag_c[s])) begin
                    hit_c[s]      = 1'b1;
                    hit_data_c[s] = cdb_data_c[c];
                end
            end
        end
    end

    // Next-state: flush/issue clear, registration capture, and wakeup while waiting
    always_comb begin
        state_d      = state_q;
        payload_d    = payload_q;
        src_valid_d  = src_valid_q;
        src_sysreg_d = src_sysreg_q;
        src_data_d   = src_data_q;
        ptr_d        = ptr_q;
        ptr_match_d  = ptr_match_q;
        age_d        = age_q;
        clear_c      = iREMOVE_VALID | (iISSUE_GRANT & matching_q);

        if (clear_c) begin
            state_d      = ST_IDLE;
            payload_d    = '0;
            src_valid_d  = '0;
            src_sysreg_d = '0;
            src_data_d   = '0;
            ptr_d        = '0;
            ptr_match_d  = 1'b0;
            age_d        = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iREGIST_VALID) begin
                        state_d      = ST_WAIT;
                        payload_d    = iREGIST_PAYLOAD;
                        src_sysreg_d = iREGIST_SRC_SYSREG;
                        for (int s = 0; s < int'(SRC_N); s++) begin
                            if (iREGIST_SRC_SYSREG[s] || iREGIST_SRC_VALID[s]) begin
                                src_valid_d[s] = 1'b1;
                                src_data_d[s]  = regist_data_c[s];
                            end else if (hit_c[s]) begin
                                src_valid_d[s] = 1'b1;
                                src_data_d[s]  = hit_data_c[s];
                            end else begin
                                src_valid_d[s] = 1'b0;
                                src_data_d[s]  = regist_data_c[s];
                            end
                        end
                        ptr_d       = iREGIST_EX_POINTER;
                        ptr_match_d = (INORDER == 0) || (iREGIST_EX_POINTER == iEX_EXECUTION_POINTER);
                        age_d       = '0;
                    end
                end
                ST_WAIT: begin
                    for (int s = 0; s < int'(SRC_N); s++) begin
                        if (!src_valid_q[s] && hit_c[s]) begin
                            src_valid_d[s] = 1'b1;
                            src_data_d[s]  = hit_data_c[s];
                        end
                    end
                    if (!ptr_match_q && (ptr_q == iEX_EXECUTION_POINTER)) begin
                        ptr_match_d = 1'b1;
                    end
                    if (age_q != {AGE_W{1'b1}}) begin
                        age_d = age_q + AGE_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        matching_d = (state_d == ST_WAIT) && (&src_valid_d) && ptr_match_d;
    end

    // Entry state registers
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q      <= ST_IDLE;
            payload_q    <= '0;
            src_valid_q  <= '0;
            src_sysreg_q <= '0;
            src_data_q   <= '0;
            ptr_q        <= '0;
            ptr_match_q  <= 1'b0;
            age_q        <= '0;
            matching_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            payload_q    <= payload_d;
            src_valid_q  <= src_valid_d;
            src_sysreg_q <= src_sysreg_d;
            src_data_q   <= src_data_d;
            ptr_q        <= ptr_d;
            ptr_match_q  <= ptr_match_d;
            age_q        <= age_d;
            matching_q   <= matching_d;
        end
    end

    assign oINFO_ENTRY_VALID = (state_q == ST_WAIT);
    assign oINFO_MATCHING    = matching_q;
    assign oINFO_PAYLOAD     = payload_q;
    assign oINFO_SRC_VALID   = src_valid_q;
    assign oINFO_SRC_SYSREG  = src_sysreg_q;
    assign oINFO_SRC_DATA    = src_data_q;
    assign oINFO_AGE         = age_q;

endmodule

// File: tb/tb_reservation_entry_gen.sv
// Bench for reservation_entry_gen: one in-order and one out-of-order instance share
// stimulus; a behavioural entry model feeds per-instance expectation queues that a
// negedge monitor drains, plus a few directed constant checks.
module tb_reservation_entry_gen;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned SRC_N  = 2;
    localparam int unsigned CDB_CH = 3;
    localparam int unsigned PAY_W  = 52;
    localparam int unsigned PTR_W  = 4;
    localparam int unsigned AGE_W  = 4;

    typedef struct packed {
        logic                         valid;
        logic [PAY_W-1:0]             pay;
        logic [SRC_N-1:0]             sv;
        logic [SRC_N-1:0]             ss;
        logic [SRC_N-1:0][DATA_W-1:0] sd;
        logic [PTR_W-1:0]             ptr;
        logic                         pm;
        logic [AGE_W-1:0]             age;
    } ent_t;

    logic                          clk = 1'b0;
    logic                          r_rst_n;
    logic                          r_remove, r_regist, r_grant;
    logic [PAY_W-1:0]              r_payload;
    logic [SRC_N-1:0]              r_srcv, r_sysreg;
    logic [SRC_N-1:0][DATA_W-1:0]  r_src_data;
    logic [PTR_W-1:0]              r_reg_ptr, r_ex_ptr;
    logic [CDB_CH-1:0]             r_cdb_v, r_cdb_wb;
    logic [CDB_CH-1:0][TAG_W-1:0]  r_cdb_name;
    logic [CDB_CH-1:0][DATA_W-1:0] r_cdb_data;

    logic                    o1_ev, o1_m, o0_ev, o0_m;
    logic [PAY_W-1:0]        o1_pay, o0_pay;
    logic [SRC_N-1:0]        o1_sv, o1_ss, o0_sv, o0_ss;
    logic [SRC_N*DATA_W-1:0] o1_sd, o0_sd;
    logic [AGE_W-1:0]        o1_age, o0_age;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t m1, m0;
    ent_t q1[$];
    ent_t q0[$];

    always #5 clk = ~clk;

    reservation_entry_gen #(.INORDER(1)) dut_io (
        .iCLOCK(clk), .inRESET(r_rst_n), .iREMOVE_VALID(r_remove), .iREGIST_VALID(r_regist),
        .iREGIST_PAYLOAD(r_payload), .iREGIST_SRC_VALID(r_srcv), .iREGIST_SRC_SYSREG(r_sysreg),
        .iREGIST_SRC_DATA(r_src_data), .iREGIST_EX_POINTER(r_reg_ptr), .iCDB_VALID(r_cdb_v),
        .iCDB_WRITEBACK(r_cdb_wb), .iCDB_REGNAME(r_cdb_name), .iCDB_DATA(r_cdb_data),
        .iEX_EXECUTION_POINTER(r_ex_ptr), .iISSUE_GRANT(r_grant),
        .oINFO_ENTRY_VALID(o1_ev), .oINFO_MATCHING(o1_m), .oINFO_PAYLOAD(o1_pay),
        .oINFO_SRC_VALID(o1_sv), .oINFO_SRC_SYSREG(o1_ss), .oINFO_SRC_DATA(o1_sd), .oINFO_AGE(o1_age)
    );

    reservation_entry_gen #(.INORDER(0)) dut_ooo (
        .iCLOCK(clk), .inRESET(r_rst_n), .iREMOVE_VALID(r_remove), .iREGIST_VALID(r_regist),
        .iREGIST_PAYLOAD(r_payload), .iREGIST_SRC_VALID(r_srcv), .iREGIST_SRC_SYSREG(r_sysreg),
        .iREGIST_SRC_DATA(r_src_data), .iREGIST_EX_POINTER(r_reg_ptr), .iCDB_VALID(r_cdb_v),
        .iCDB_WRITEBACK(r_cdb_wb), .iCDB_REGNAME(r_cdb_name), .iCDB_DATA(r_cdb_data),
        .iEX_EXECUTION_POINTER(r_ex_ptr), .iISSUE_GRANT(r_grant),
        .oINFO_ENTRY_VALID(o0_ev), .oINFO_MATCHING(o0_m), .oINFO_PAYLOAD(o0_pay),
        .oINFO_SRC_VALID(o0_sv), .oINFO_SRC_SYSREG(o0_ss), .oINFO_SRC_DATA(o0_sd), .oINFO_AGE(o0_age)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ready to issue: occupied, every operand present, in-order slot reached
    function automatic bit ent_match(input ent_t e);
        return e.valid && (e.sv == {SRC_N{1'b1}}) && e.pm;
    endfunction

    // Index of the first (lowest) channel delivering this tag, or -1
    function automatic int first_hit(input logic [TAG_W-1:0] tag);
        for (int c = 0; c < int'(CDB_CH); c++)
            if (r_cdb_v[c] && r_cdb_wb[c] && r_cdb_name[c] == tag) return c;
        return -1;
    endfunction

    // Entry contents after the coming clock edge, given the current inputs
    function automatic ent_t next_ent(input ent_t e, input bit inorder);
        ent_t n;
        int   h;
        n = e;
        if (!r_rst_n) return '0;
        if (r_remove || (r_grant && ent_match(e))) return '0;
        if (!e.valid) begin
            if (r_regist) begin
                n       = '0;
                n.valid = 1'b1;
                n.pay   = r_payload;
                n.ss    = r_sysreg;
                for (int s = 0; s < int'(SRC_N); s++) begin
                    n.sd[s] = r_src_data[s];
                    if (r_sysreg[s] || r_srcv[s]) begin
                        n.sv[s] = 1'b1;
                    end else begin
                        h = first_hit(r_src_data[s][TAG_W-1:0]);
                        n.sv[s] = (h >= 0);
                        if (h >= 0) n.sd[s] = r_cdb_data[h];
                    end
                end
                n.ptr = r_reg_ptr;
                n.pm  = !inorder || (r_reg_ptr == r_ex_ptr);
            end
        end else begin
            for (int s = 0; s < int'(SRC_N); s++) begin
                if (!e.sv[s]) begin
                    h = first_hit(e.sd[s][TAG_W-1:0]);
                    if (h >= 0) begin
                        n.sv[s] = 1'b1;
                        n.sd[s] = r_cdb_data[h];
                    end
                end
            end
            if (!e.pm && e.ptr == r_ex_ptr) n.pm = 1'b1;
            if (int'(e.age) < (1 << AGE_W) - 1) n.age = AGE_W'(int'(e.age) + 1);
        end
        return n;
    endfunction

    task automatic check_ent(input string who, input ent_t e, input logic ev, input logic m,
                             input logic [PAY_W-1:0] pay, input logic [SRC_N-1:0] sv,
                             input logic [SRC_N-1:0] ss, input logic [SRC_N*DATA_W-1:0] sd,
                             input logic [AGE_W-1:0] age);
        chk({who, ".entry_valid"}, 64'(ev), 64'(e.valid));
        chk({who, ".matching"}, 64'(m), 64'(ent_match(e)));
        chk({who, ".payload"}, 64'(pay), 64'(e.pay));
        chk({who, ".src_valid"}, 64'(sv), 64'(e.sv));
        chk({who, ".src_sysreg"}, 64'(ss), 64'(e.ss));
        chk({who, ".src_data"}, 64'(sd), 64'(e.sd));
        chk({who, ".age"}, 64'(age), 64'(e.age));
    endtask

    // Monitor: each negedge shows the result of the previous edge
    always @(negedge clk) begin
        ent_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check_ent("io", e, o1_ev, o1_m, o1_pay, o1_sv, o1_ss, o1_sd, o1_age);
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check_ent("ooo", e, o0_ev, o0_m, o0_pay, o0_sv, o0_ss, o0_sd, o0_age);
        end
    end

    // Drive window opens just after the monitor has sampled
    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_in();
        r_rst_n = 1'b1; r_remove = 1'b0; r_regist = 1'b0; r_grant = 1'b0;
        r_payload = '0; r_srcv = '0; r_sysreg = '0; r_src_data = '0; r_reg_ptr = '0;
        r_cdb_v = '0; r_cdb_wb = '0; r_cdb_name = '0; r_cdb_data = '0;
    endtask

    task automatic commit();
        m1 = next_ent(m1, 1'b1);
        m0 = next_ent(m0, 1'b0);
        q1.push_back(m1);
        q0.push_back(m0);
    endtask

    task automatic reg_both_valid(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                                  input logic [PTR_W-1:0] p);
        r_regist = 1'b1; r_payload = PAY_W'(52'h1234_5678_9ABC); r_srcv = 2'b11;
        r_src_data[0] = d0; r_src_data[1] = d1; r_reg_ptr = p;
    endtask

    initial begin
        m1 = '0; m0 = '0;
        clear_in();
        r_ex_ptr = '0;
        r_rst_n  = 1'b0;
        sync(); clear_in(); r_rst_n = 1'b0; commit();
        sync(); clear_in(); commit();

        // Both sources ready at registration, then age climbs and saturates
        sync(); clear_in(); reg_both_valid(32'h11, 32'h22, 4'd0); commit();
        sync(); clear_in();
        chk("t1.entry_valid", 64'(o1_ev), 64'd1);
        chk("t1.matching", 64'(o1_m), 64'd1);
        chk("t1.src_data", 64'(o1_sd), 64'h0000_0022_0000_0011);
        chk("t1.age0", 64'(o1_age), 64'd0);
        commit();
        sync(); clear_in(); chk("t1.age1", 64'(o1_age), 64'd1); commit();
        repeat (20) begin sync(); clear_in(); commit(); end
        sync(); clear_in(); chk("t1.age_sat", 64'(o1_age), 64'd15);
        r_grant = 1'b1; commit();
        sync(); clear_in();
        chk("t1.grant_clear_valid", 64'(o1_ev), 64'd0);
        chk("t1.grant_clear_data", 64'(o1_sd), 64'd0);
        commit();

        // Same-cycle bypass at registration from channel 1
        sync(); clear_in();
        r_regist = 1'b1; r_srcv = 2'b10; r_src_data[0] = 32'h05; r_src_data[1] = 32'h77;
        r_cdb_v[1] = 1'b1; r_cdb_wb[1] = 1'b1; r_cdb_name[1] = 6'h05; r_cdb_data[1] = 32'hDEADBEEF;
        commit();
        sync(); clear_in();
        chk("t2.src_valid", 64'(o1_sv), 64'd3);
        chk("t2.src0_data", 64'(o1_sd[31:0]), 64'hDEADBEEF);
        r_remove = 1'b1; commit();

        // Two channels hit one source: lowest wins, unless it does not write back
        for (int rep = 0; rep < 2; rep++) begin
            sync(); clear_in();
            r_regist = 1'b1; r_srcv = 2'b01; r_src_data[0] = 32'h33; r_src_data[1] = 32'h0A;
            commit();
            sync(); clear_in();
            chk("t3.pending", 64'(o1_sv), 64'd1);
            r_cdb_v = 3'b101; r_cdb_wb = (rep == 0) ? 3'b101 : 3'b100;
            r_cdb_name[0] = 6'h0A; r_cdb_name[2] = 6'h0A;
            r_cdb_data[0] = 32'h1; r_cdb_data[2] = 32'h2;
            commit();
            sync(); clear_in();
            chk(rep == 0 ? "t3.ch0_wins" : "t3.ch2_wb_only", 64'(o1_sd[63:32]), rep == 0 ? 64'h1 : 64'h2);
            chk("t3.woken", 64'(o1_m), 64'd1);
            r_remove = 1'b1; commit();
        end

        // In-order gating: grant ignored while not matching, wake on pointer arrival
        sync(); clear_in(); r_ex_ptr = 4'd1; reg_both_valid(32'h1, 32'h2, 4'd3); commit();
        sync(); clear_in();
        chk("t4.io_blocked", 64'(o1_m), 64'd0);
        chk("t4.ooo_ready", 64'(o0_m), 64'd1);
        r_grant = 1'b1; commit();
        sync(); clear_in();
        chk("t4.io_retained", 64'(o1_ev), 64'd1);
        chk("t4.ooo_issued", 64'(o0_ev), 64'd0);
        r_ex_ptr = 4'd3; commit();
        sync(); clear_in();
        chk("t4.io_wake", 64'(o1_m), 64'd1);
        r_grant = 1'b1; commit();
        sync(); clear_in();
        chk("t4.io_issued", 64'(o1_ev), 64'd0);
        chk("t4.io_payload0", 64'(o1_pay), 64'd0);
        r_ex_ptr = 4'd0; commit();

        // Remove beats a coincident registration
        sync(); clear_in(); reg_both_valid(32'h5, 32'h6, 4'd0); r_remove = 1'b1; commit();
        sync(); clear_in(); chk("t5.remove_wins", 64'(o1_ev), 64'd0); commit();

        // Asynchronous reset in the middle of WAIT
        sync(); clear_in(); r_regist = 1'b1; r_src_data[0] = 32'h3F; r_src_data[1] = 32'h3E; commit();
        sync(); clear_in();
        chk("t6.waiting", 64'(o1_ev), 64'd1);
        r_rst_n = 1'b0;
        #1;
        chk("t6.async_valid", 64'(o1_ev), 64'd0);
        chk("t6.async_data", 64'(o1_sd), 64'd0);
        commit();
        sync(); clear_in(); commit();

        // Randomized traffic with a narrow tag space to force frequent hits
        for (int cyc = 0; cyc < 2000; cyc++) begin
            sync(); clear_in();
            r_regist  = ($urandom_range(0, 1) == 1);
            r_remove  = ($urandom_range(0, 15) == 0);
            r_grant   = ($urandom_range(0, 2) == 0);
            r_payload = PAY_W'({$urandom, $urandom});
            r_srcv    = SRC_N'($urandom_range(0, 3));
            r_sysreg  = ($urandom_range(0, 7) == 0) ? SRC_N'($urandom_range(1, 3)) : '0;
            for (int s = 0; s < int'(SRC_N); s++) begin
                r_src_data[s] = $urandom;
                r_src_data[s][TAG_W-1:0] = TAG_W'($urandom_range(0, 7));
            end
            r_reg_ptr = PTR_W'($urandom_range(0, 3));
            r_ex_ptr  = PTR_W'($urandom_range(0, 3));
            for (int c = 0; c < int'(CDB_CH); c++) begin
                r_cdb_v[c]    = ($urandom_range(0, 2) == 0);
                r_cdb_wb[c]   = ($urandom_range(0, 3) != 0);
                r_cdb_name[c] = TAG_W'($urandom_range(0, 7));
                r_cdb_data[c] = $urandom;
            end
            commit();
        end

        sync(); clear_in();
        sync();
        chk("scoreboard_drained", 64'(q1.size() + q0.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_entry_gen.md
Name: reservation_entry_gen

Overview:
Single generic reservation-station entry, parametrised in data width, tag width, source count and CDB channel count. It captures a dispatched instruction and snoops N result buses to wake its operands. It optionally gates issue on an in-order execution pointer and keeps a saturating age count for oldest-first selection. It is instantiated per entry in the ALU/branch/LDST schedulers and holds the slot until the issue grant.

Parameters:
DATA_W, 32, operand data width (must be >= TAG_W)
TAG_W, 6, physical register name width; pending source stores its tag in data[TAG_W-1:0]
SRC_N, 2, number of source operands
CDB_CH, 3, number of common data bus channels; channel 0 has highest priority
PAY_W, 52, opaque payload width (cmd, ldst flags, dest name/sysreg, commit tag, pc ...)
PTR_W, 4, in-order execution pointer width
INORDER, 1, 1 = issue gated by pointer match; 0 = pointer ignored (match forced 1)
AGE_W, 4, age counter width

Ports:
iCLOCK  in  1  clock
inRESET  in  1  reset, asynchronous, active-low
iREMOVE_VALID  in  1  flush entry
iREGIST_VALID  in  1  register new instruction
iREGIST_PAYLOAD  in  PAY_W  opaque payload
iREGIST_SRC_VALID  in  SRC_N  source already holds data
iREGIST_SRC_SYSREG  in  SRC_N  source is sysreg (always valid)
iREGIST_SRC_DATA  in  SRC_N*DATA_W  data, or tag in low TAG_W bits
iREGIST_EX_POINTER  in  PTR_W  in-order slot of this instruction
iCDB_VALID  in  CDB_CH  channel result valid
iCDB_WRITEBACK  in  CDB_CH  channel writes a register (tie 1 for LDST)
iCDB_REGNAME  in  CDB_CH*TAG_W  destination tag per channel
iCDB_DATA  in  CDB_CH*DATA_W  result per channel
iEX_EXECUTION_POINTER  in  PTR_W  current in-order pointer
iISSUE_GRANT  in  1  selector issues this entry
oINFO_ENTRY_VALID  out  1  entry occupied
oINFO_MATCHING  out  1  ready to issue
oINFO_PAYLOAD  out  PAY_W  stored payload
oINFO_SRC_VALID  out  SRC_N  per-source ready
oINFO_SRC_SYSREG  out  SRC_N  stored sysreg flags
oINFO_SRC_DATA  out  SRC_N*DATA_W  stored operands
oINFO_AGE  out  AGE_W  cycles since registration, saturating

Behaviour:
- Reset: every register and output is 0; state is IDLE.
- Priority per cycle: reset > (iREMOVE_VALID | (iISSUE_GRANT & oINFO_MATCHING)) > state action. Clearing returns to IDLE with all fields 0 on the next edge.
- iISSUE_GRANT while oINFO_MATCHING=0 is ignored; the entry is unchanged.
- IDLE: iREGIST_VALID=1 causes a transition to WAIT. The entry latches the payload and sysreg flags, and age=0. For each source s:
  - If SYSREG or VALID: valid=1, data=input.
  - Otherwise, if there is a hit on the lowest-index channel c with VALID&WRITEBACK and REGNAME==data[TAG_W-1:0]: valid=1, data=CDB data (same-cycle bypass).
  - Otherwise: valid=0, data=input (holds tag).
- Pointer at registration: if equal to iEX_EXECUTION_POINTER, or INORDER=0, ptr_match=1. Otherwise store the pointer and set ptr_match=0.
- WAIT:
  - Each invalid source snoops the CDB with the same priority rule. Valid sources never change.
  - If ptr_match=0 and the stored pointer equals the current pointer, ptr_match=1.
  - Age increments by 1 per cycle and holds at 2^AGE_W-1.
  - iREGIST_VALID is ignored.
- oINFO_MATCHING = WAIT & all src valid & ptr_match. It is combinational from registers only, so a wakeup is visible 1 cycle after the CDB beat.
- All outputs are driven directly from registers. No combinational path from inputs to outputs.
- Multiple simultaneous hits on one source: the lowest channel index wins. One channel may wake several sources in the same cycle.
- Async reset asserted mid-WAIT clears the entry immediately. After release the entry is IDLE.
- Registration coinciding with iREMOVE_VALID: remove wins and the entry stays IDLE.

Test Plan:
- Register with both src VALID (0x11, 0x22), pointer equal -> next cycle ENTRY_VALID=1, MATCHING=1, SRC_DATA={0x22,0x11}, AGE=0; then AGE counts 1, 2, ... and saturates at 15.
- Register src0 tag 0x05 pending while ch1 broadcasts tag 0x05 data 0xDEADBEEF with WRITEBACK=1 the same cycle -> src0 valid, data 0xDEADBEEF after 1 cycle.
- Pending src1 tag 0x0A; ch0 and ch2 both hit the same cycle with data 0x1 and 0x2 -> src1=0x1. A repeat with ch0 WRITEBACK=0 -> src1=0x2.
- INORDER=1: register pointer 3 while current pointer is 1 -> MATCHING=0. Pointer goes to 3 -> MATCHING=1 the next cycle. Same stimulus with INORDER=0 -> MATCHING=1 immediately.
- Grant while MATCHING=0 -> entry retained. Grant while MATCHING=1 -> ENTRY_VALID=0 and all outputs 0 the next cycle.
- iREMOVE_VALID together with iREGIST_VALID, and async reset mid-WAIT -> entry IDLE, all outputs 0.
